// File: rtl/operand_stack.sv
// operand_stack: 8-bit operand stack feeding the ALU with registered top/next entries
// Ports: clk, rst (sync active-low); op_valid/op/din request an op
//   (00 PUSH, 01 POP, 10 REPL1, 11 REPL2);
//   tos/nos are the top two entries; count/empty/full give the fill level;
//   op_done pulses one cycle after each op_valid;
//   overflow/underflow are sticky illegal-op flags.
module operand_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              op_done,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_REPL1 = 2'b10;
  localparam logic [PTR_W:0] C0 = '0, C1 = 1, C2 = 2, C3 = 3;
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] I1 = 1, I2 = 2, I3 = 3;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tos_q, tos_d, nos_q, nos_d, below_nos;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  cl, wr_idx;
  logic              done_q, ovf_q, ovf_d, unf_q, unf_d;
  logic              is_push, legal, acc, wr_en;
  // Index arithmetic is modulo DEPTH on the low count bits; only legal ops use it,
  // so the results always land on a real entry.
  always_comb begin
    cl        = count_q[PTR_W-1:0];
    is_push   = op == OP_PUSH;
    legal     = is_push ? (count_q != C_FULL) : (op == 2'b11 ? count_q >= C2 : count_q != C0);
    acc       = op_valid && legal;
    below_nos = count_q >= C3 ? mem[cl - I3] : '0;
    count_d   = !acc ? count_q : is_push ? count_q + C1 : op == OP_REPL1 ? count_q : count_q - C1;
    tos_d     = !acc ? tos_q : op == OP_POP ? nos_q : din;
    nos_d     = !acc ? nos_q : is_push ? tos_q : op == OP_REPL1 ? nos_q : below_nos;
    wr_en     = acc && op != OP_POP;
    wr_idx    = is_push ? cl : op == OP_REPL1 ? cl - I1 : cl - I2;
    ovf_d     = ovf_q | (op_valid & is_push & ~legal);
    unf_d     = unf_q | (op_valid & ~is_push & ~legal);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      done_q  <= op_valid;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // Storage has no reset; gating on rst keeps a discarded op from touching it.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_idx] <= din;
  end
  assign tos       = tos_q;
  assign nos       = nos_q;
  assign count     = count_q;
  assign empty     = count_q == C0;
  assign full      = count_q == C_FULL;
  assign op_done   = done_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed self-checking bench for operand_stack
module tb_operand_stack;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, REPL1 = 2'b10, REPL2 = 2'b11;
  logic       clk = 1'b0, rst = 1'b0, op_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] din = '0, tos, nos;
  logic [4:0] count;
  logic       empty, full, op_done, overflow, underflow;
  int total = 0, bad = 0;

  operand_stack dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .op_done(op_done), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    din = d;
  endtask

  task automatic idle();
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset and idle, then reset wins over a simultaneous push
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tos", tos, 0);
    chk("rst_nos", nos, 0);
    chk("rst_done", op_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1;
    op = PUSH;
    din = 8'h55;
    @(negedge clk);
    rst = 1'b1;
    op_valid = 1'b0;
    chk("rst_push_count", count, 0);
    chk("rst_push_done", op_done, 0);
    // 2: back-to-back pushes then REPL2
    drive(PUSH, 8'h12);
    drive(PUSH, 8'h34);
    idle();
    chk("t2_tos", tos, 8'h34);
    chk("t2_nos", nos, 8'h12);
    chk("t2_count", count, 2);
    chk("t2_done", op_done, 1);
    drive(REPL2, 8'h46);
    idle();
    chk("t2_r2_tos", tos, 8'h46);
    chk("t2_r2_nos", nos, 0);
    chk("t2_r2_count", count, 1);
    idle();
    chk("t2_done_drop", op_done, 0);
    // 3: push three, pop, replace top, drain
    do_reset();
    drive(PUSH, 8'hA0);
    drive(PUSH, 8'hB0);
    drive(PUSH, 8'hC0);
    drive(POP, 8'h00);
    idle();
    chk("t3_pop_tos", tos, 8'hB0);
    chk("t3_pop_nos", nos, 8'hA0);
    chk("t3_pop_count", count, 2);
    drive(REPL1, 8'h4F);
    idle();
    chk("t3_r1_tos", tos, 8'h4F);
    chk("t3_r1_nos", nos, 8'hA0);
    chk("t3_r1_count", count, 2);
    drive(POP, 8'h00);
    idle();
    chk("t3_pop2_tos", tos, 8'hA0);
    chk("t3_pop2_nos", nos, 0);
    drive(POP, 8'h00);
    idle();
    chk("t3_pop3_tos", tos, 0);
    chk("t3_pop3_empty", empty, 1);
    chk("t3_unf", underflow, 0);
    // 4: fill, overflow, REPL2 from full
    do_reset();
    for (int i = 0; i < 16; i++) drive(PUSH, 8'(i));
    idle();
    chk("t4_full", full, 1);
    chk("t4_tos", tos, 8'h0F);
    chk("t4_nos", nos, 8'h0E);
    chk("t4_count", count, 16);
    drive(PUSH, 8'hFF);
    idle();
    chk("t4_ovf", overflow, 1);
    chk("t4_ovf_tos", tos, 8'h0F);
    chk("t4_ovf_count", count, 16);
    chk("t4_ovf_done", op_done, 1);
    drive(REPL2, 8'h1D);
    idle();
    chk("t4_r2_count", count, 15);
    chk("t4_r2_full", full, 0);
    chk("t4_r2_tos", tos, 8'h1D);
    chk("t4_r2_nos", nos, 8'h0D);
    drive(POP, 8'h00);
    idle();
    chk("t4_pop_tos", tos, 8'h0D);
    chk("t4_pop_nos", nos, 8'h0C);
    chk("t4_ovf_sticky", overflow, 1);
    // 5: underflow from empty and from a short REPL2
    do_reset();
    drive(POP, 8'h00);
    idle();
    chk("t5_unf", underflow, 1);
    chk("t5_count", count, 0);
    chk("t5_done", op_done, 1);
    chk("t5_ovf", overflow, 0);
    drive(PUSH, 8'h07);
    drive(REPL2, 8'h99);
    idle();
    chk("t5_r2_count", count, 1);
    chk("t5_r2_tos", tos, 8'h07);
    chk("t5_unf_sticky", underflow, 1);
    do_reset();
    chk("t5_unf_clr", underflow, 0);
    // 6: reset mid-sequence discards the concurrent push
    drive(PUSH, 8'h11);
    drive(PUSH, 8'h22);
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1;
    op = PUSH;
    din = 8'h33;
    @(negedge clk);
    rst = 1'b1;
    op_valid = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_tos", tos, 0);
    chk("t6_nos", nos, 0);
    chk("t6_done", op_done, 0);
    drive(PUSH, 8'h44);
    idle();
    chk("t6_push_tos", tos, 8'h44);
    chk("t6_push_nos", nos, 0);
    chk("t6_push_count", count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware operand stack for the multi-cycle stack-based processor; sits directly upstream of the ALU.
- Holds 8-bit operands and presents the top two entries as registered outputs: top-of-stack (tos) and next-on-stack (nos).
- These outputs drive the ALU Op1/Op2 inputs.
- The controller pushes immediates/memory data and writes ALU results back with single-cycle replace operations.

Parameters:
DATA_W, 8, operand width (matches ALU operand width)
DEPTH, 16, number of stack entries
PTR_W, 4, log2(DEPTH); count is PTR_W+1 bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (rst=0 at a rising clk edge resets the block)
op_valid  input  1  qualifies op/din for this cycle
op  input  2  00 PUSH, 01 POP, 10 REPL1 (pop 1, push din), 11 REPL2 (pop 2, push din)
din  input  DATA_W  data written by PUSH/REPL1/REPL2
tos  output  DATA_W  registered top entry (Op1 to ALU)
nos  output  DATA_W  registered second entry (Op2 to ALU)
count  output  PTR_W+1  registered number of valid entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
op_done  output  1  one-cycle pulse, cycle after any op_valid
overflow  output  1  sticky: PUSH attempted while full
underflow  output  1  sticky: pop-type op with insufficient entries

Behaviour:
- Reset (rst=0 at posedge):
  - count=0, tos=0, nos=0, op_done=0, overflow=0, underflow=0.
  - empty=1, full=0.
  - Storage contents are don't-care.
  - Reset has priority over any op_valid in the same cycle; an op presented with reset is discarded.
- All state updates on the rising clk edge. One op accepted per cycle; back-to-back ops every cycle are legal. No stall or backpressure.
- Ops are applied when op_valid=1. Legality conditions and effects:
  - PUSH:
    - Legal when count<DEPTH.
    - mem[count]<=din; count+1; tos<=din; nos<=old tos.
  - POP:
    - Legal when count>=1. count-1.
    - tos<=old nos.
    - nos<=mem[count-3] if count>=3, else 0.
  - REPL1:
    - Legal when count>=1. count unchanged.
    - mem[count-1]<=din; tos<=din; nos unchanged.
  - REPL2:
    - Legal when count>=2. count-1.
    - mem[count-2]<=din; tos<=din.
    - nos<=mem[count-3] if count>=3, else 0.
    - Legal when full: net count decreases.
- Illegal op:
  - No change to storage, count, tos or nos.
  - PUSH when full sets overflow.
  - POP/REPL1 when empty, or REPL2 with count<2, sets underflow.
  - Flags stay set until reset.
- Latency: op_done=1 exactly one cycle after each op_valid=1 cycle, legal or not. tos/nos/count/empty/full reflect the op in that same op_done cycle.
- Output invariants:
  - tos=0 whenever count==0.
  - nos=0 whenever count<2.
  - empty and full are derived from registered count, so they are glitch-free.
- Arithmetic: no wrap-around. count is saturated by the legality checks. Storage indices always lie in 0..DEPTH-1.
- op_valid=0: all state holds; op_done=0.

Test Plan:
1. Reset then idle -> count=0, empty=1, tos=0, nos=0, all flags 0. Assert rst=0 while op_valid=1 PUSH 0x55 -> count stays 0.
2. PUSH 0x12, PUSH 0x34, back-to-back cycles -> after 2nd op_done: tos=0x34, nos=0x12, count=2. Then REPL2 din=0x46 (ALU sum) -> tos=0x46, nos=0, count=1.
3. PUSH 0xA0,0xB0,0xC0; POP -> tos=0xB0, nos=0xA0, count=2. REPL1 din=0x4F -> tos=0x4F, nos=0xA0, count=2.
4. Push 16 values 0x00..0x0F -> full=1, tos=0x0F, nos=0x0E. PUSH 0xFF -> overflow=1, tos=0x0F, count=16, op_done pulses. REPL2 din=0x1D -> count=15, full=0, tos=0x1D, nos=0x0D.
5. From reset, POP -> underflow=1, count=0. PUSH 0x07 then REPL2 -> count=1, tos=0x07, underflow stays 1. Reset -> underflow=0.
6. Mid-sequence reset: push 0x11,0x22, then assert rst=0 together with PUSH 0x33 -> next cycle count=0, tos=0, nos=0, op_done=0. Then PUSH 0x44 -> tos=0x44, nos=0.
